// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler
//
// Serial front end of the UART receive path. The asynchronous rx_in line is
// brought into the Clk domain through a two-flop synchroniser. A falling edge
// on the synchronised line starts a frame. The start bit is re-checked at
// mid-bit so that short glitches are rejected. Each data bit is then sampled
// at mid-bit and handed to the downstream SIPO register, LSB first, as a
// data_bit value plus a one-cycle shift strobe. The stop bit is checked at
// mid-bit and a framing error is reported alongside frame_done.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit follows the data bits. It is checked
//   without producing a shift strobe, and the result is reported on
//   parity_error.
//
// Parameters:
//   CLKS_PER_BIT  Clk cycles per UART bit period (>= 4, even)
//   DATA_BITS     data bits per frame (1..8)
//
// Ports:
//   Clk            system clock, rising edge
//   reset          synchronous active-high reset
//   rx_in          asynchronous serial line, idles high
//   data_bit       sampled data bit, valid while shift is high, held otherwise
//   shift          one-cycle strobe per data bit
//   sipo_enable    high from DATA entry through the stop-bit sample
//   frame_done     one-cycle pulse at the stop-bit sample point
//   framing_error  stop-bit result, updated with each frame_done
//   busy           high whenever the sampler is not idle
//   parity_error   even-parity result (UART_RX_PARITY_EN only)

module uart_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic Clk,
  input  logic reset,
  input  logic rx_in,
  output logic data_bit,
  output logic shift,
  output logic sipo_enable,
  output logic frame_done,
  output logic framing_error,
`ifdef UART_RX_PARITY_EN
  output logic parity_error,
`endif
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } stateT;

  stateT            state_q, state_d;
  logic             rxMeta_q, rxSync_q;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic             dataBit_q, dataBit_d;
  logic             shift_q, shift_d;
  logic             sipoEnable_q, sipoEnable_d;
  logic             frameDone_q, frameDone_d;
  logic             framingError_q, framingError_d;
`ifdef UART_RX_PARITY_EN
  logic             parityAcc_q, parityAcc_d;
  logic             parityError_q, parityError_d;
`endif

  // Two-flop synchroniser for the asynchronous line. Both stages reset high
  // so that leaving reset never looks like a start bit.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_in;
      rxSync_q <= rxMeta_q;
    end
  end

  // State and registered outputs. Every output is driven from a flop, so
  // data_bit and shift always change on the same edge.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q        <= IDLE;
      baudCnt_q      <= '0;
      bitIdx_q       <= '0;
      dataBit_q      <= 1'b0;
      shift_q        <= 1'b0;
      sipoEnable_q   <= 1'b0;
      frameDone_q    <= 1'b0;
      framingError_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityAcc_q    <= 1'b0;
      parityError_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      baudCnt_q      <= baudCnt_d;
      bitIdx_q       <= bitIdx_d;
      dataBit_q      <= dataBit_d;
      shift_q        <= shift_d;
      sipoEnable_q   <= sipoEnable_d;
      frameDone_q    <= frameDone_d;
      framingError_q <= framingError_d;
`ifdef UART_RX_PARITY_EN
      parityAcc_q    <= parityAcc_d;
      parityError_q  <= parityError_d;
`endif
    end
  end

  // Next-state logic. The bit-period counter free-runs inside a bit and is
  // cleared on every state change, so each sample point lands a whole bit
  // period after the previous one. The start bit is checked at half a period,
  // which aligns all later samples to mid-bit. Strobes default low and
  // held values default to their current contents.
  always_comb begin
    state_d        = state_q;
    baudCnt_d      = baudCnt_q + CNT_W'(1);
    bitIdx_d       = bitIdx_q;
    dataBit_d      = dataBit_q;
    shift_d        = 1'b0;
    sipoEnable_d   = sipoEnable_q;
    frameDone_d    = 1'b0;
    framingError_d = framingError_q;
`ifdef UART_RX_PARITY_EN
    parityAcc_d    = parityAcc_q;
    parityError_d  = parityError_q;
`endif

    case (state_q)
      IDLE: begin
        baudCnt_d = '0;
        if (!rxSync_q) begin
          state_d = START;
        end
      end

      START: begin
        if (baudCnt_q == HALF_LAST) begin
          baudCnt_d = '0;
          if (!rxSync_q) begin
            state_d      = DATA;
            bitIdx_d     = '0;
            sipoEnable_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parityAcc_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baudCnt_q == BIT_LAST) begin
          baudCnt_d = '0;
          dataBit_d = rxSync_q;
          shift_d   = 1'b1;
          bitIdx_d  = bitIdx_q + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
          parityAcc_d = parityAcc_q ^ rxSync_q;
`endif
          if (bitIdx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baudCnt_q == BIT_LAST) begin
          baudCnt_d     = '0;
          parityError_d = parityAcc_q ^ rxSync_q;
          state_d       = STOP;
        end
      end
`endif

      STOP: begin
        if (baudCnt_q == BIT_LAST) begin
          baudCnt_d    = '0;
          frameDone_d  = 1'b1;
          sipoEnable_d = 1'b0;
          if (rxSync_q) begin
            framingError_d = 1'b0;
            state_d        = IDLE;
          end else begin
            framingError_d = 1'b1;
            state_d        = WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) must go high again before a new frame can
      // start, otherwise it would re-trigger endlessly.
      WAIT_IDLE: begin
        baudCnt_d = '0;
        if (rxSync_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        baudCnt_d = '0;
      end
    endcase
  end

  assign data_bit      = dataBit_q;
  assign shift         = shift_q;
  assign sipo_enable   = sipoEnable_q;
  assign frame_done    = frameDone_q;
  assign framing_error = framingError_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parityError_q;
`endif

endmodule
